bus8_arbiter_x2: RTL and testbench

- Round-robin arbiter that shares one Bus8 register bus (CS / Wr_Rd_n / Addr8 / Wr_Data / Rd_Data / Rd_DV) between two requesters, M0 and M1.
- Each requester posts one transaction at a time. The arbiter serialises the transactions onto the slave bus, waits for read data with a bounded timeout, and returns a completion pulse to the owning requester.
- Sits between bus drivers (CPU bridge, UART command decoder) and slave blocks such as the Bus8 register banks.

---
 rtl/bus8_arbiter_x2_if.sv | 50 +++++
 rtl/bus8_arbiter_x2.sv | 158 +++++++++++++++
 tb/tb_bus8_arbiter_x2.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus8_arbiter_x2_if.sv
// Bus8 arbiter signal bundle: two requester ports plus the shared slave bus.
// The master modport is the arbiter's view (it masters the shared bus);
// the slave modport is the environment's view (requesters and bus slave).
interface bus8_arbiter_x2_if;
    logic       i_M0_Req;
    logic       i_M0_Wr_Rd_n;
    logic [7:0] i_M0_Addr8;
    logic [7:0] i_M0_Wr_Data;
    logic       o_M0_Done;
    logic [7:0] o_M0_Rd_Data;
    logic       o_M0_Timeout;

    logic       i_M1_Req;
    logic       i_M1_Wr_Rd_n;
    logic [7:0] i_M1_Addr8;
    logic [7:0] i_M1_Wr_Data;
    logic       o_M1_Done;
    logic [7:0] o_M1_Rd_Data;
    logic       o_M1_Timeout;

    logic       o_Bus_CS;
    logic       o_Bus_Wr_Rd_n;
    logic [7:0] o_Bus_Addr8;
    logic [7:0] o_Bus_Wr_Data;
    logic [7:0] i_Bus_Rd_Data;
    logic       i_Bus_Rd_DV;

    logic       o_Grant;
    logic       o_Busy;

    modport master (
        input  i_M0_Req, i_M0_Wr_Rd_n, i_M0_Addr8, i_M0_Wr_Data,
        output o_M0_Done, o_M0_Rd_Data, o_M0_Timeout,
        input  i_M1_Req, i_M1_Wr_Rd_n, i_M1_Addr8, i_M1_Wr_Data,
        output o_M1_Done, o_M1_Rd_Data, o_M1_Timeout,
        output o_Bus_CS, o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data,
        input  i_Bus_Rd_Data, i_Bus_Rd_DV,
        output o_Grant, o_Busy
    );

    modport slave (
        output i_M0_Req, i_M0_Wr_Rd_n, i_M0_Addr8, i_M0_Wr_Data,
        input  o_M0_Done, o_M0_Rd_Data, o_M0_Timeout,
        output i_M1_Req, i_M1_Wr_Rd_n, i_M1_Addr8, i_M1_Wr_Data,
        input  o_M1_Done, o_M1_Rd_Data, o_M1_Timeout,
        input  o_Bus_CS, o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data,
        output i_Bus_Rd_Data, i_Bus_Rd_DV,
        input  o_Grant, o_Busy
    );
endinterface

// File: rtl/bus8_arbiter_x2.sv
// Two-requester round-robin arbiter for a Bus8 register bus.
// Serialises one transaction at a time onto the slave bus, waits for read
// data with a bounded timeout and returns a completion pulse to the owner.
//
// state   | meaning
// IDLE    | no transaction; arbitrate among pending requests
// ISSUE   | chip-select pulse with the latched fields on the bus
// WAIT_RD | waiting for slave read data or timeout
// DONE    | completion pulse to the granted master
module bus8_arbiter_x2 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              i_Bus_Clk,
    input  logic              i_Bus_Rst,
    bus8_arbiter_x2_if.master bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Final counter value before a read is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state_q,   state_d;
    logic       grant_q,   grant_d;
    logic       last_q,    last_d;
    logic       wr_q,      wr_d;
    logic [7:0] addr_q,    addr_d;
    logic [7:0] wdata_q,   wdata_d;
    logic [7:0] cnt_q,     cnt_d;
    logic [7:0] m0_rd_q,   m0_rd_d;
    logic       m0_tmo_q,  m0_tmo_d;
    logic [7:0] m1_rd_q,   m1_rd_d;
    logic       m1_tmo_q,  m1_tmo_d;

    logic       sel;
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    // Next-state and datapath decisions for the transaction sequencer.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        m0_rd_d  = m0_rd_q;
        m0_tmo_d = m0_tmo_q;
        m1_rd_d  = m1_rd_q;
        m1_tmo_d = m1_tmo_q;
        sel      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_M0_Req || bus.i_M1_Req) begin
                    // On a tie the master that did not go last wins.
                    if (bus.i_M0_Req && bus.i_M1_Req) sel = ~last_q;
                    else                              sel = bus.i_M1_Req;
                    grant_d = sel;
                    wr_d    = sel ? bus.i_M1_Wr_Rd_n : bus.i_M0_Wr_Rd_n;
                    addr_d  = sel ? bus.i_M1_Addr8   : bus.i_M0_Addr8;
                    wdata_d = sel ? bus.i_M1_Wr_Data : bus.i_M0_Wr_Data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_q) begin
                    // Writes complete without a timeout; read data is left as is.
                    if (grant_q) m1_tmo_d = 1'b0;
                    else         m0_tmo_d = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (bus.i_Bus_Rd_DV) begin
                    if (grant_q) begin
                        m1_rd_d  = bus.i_Bus_Rd_Data;
                        m1_tmo_d = 1'b0;
                    end else begin
                        m0_rd_d  = bus.i_Bus_Rd_Data;
                        m0_tmo_d = 1'b0;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        if (grant_q) begin
                            m1_rd_d  = 8'h00;
                            m1_tmo_d = 1'b1;
                        end else begin
                            m0_rd_d  = 8'h00;
                            m0_tmo_d = 1'b1;
                        end
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst) begin
        if (i_Bus_Rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            cnt_q    <= 8'h00;
            m0_rd_q  <= 8'h00;
            m0_tmo_q <= 1'b0;
            m1_rd_q  <= 8'h00;
            m1_tmo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            m0_rd_q  <= m0_rd_d;
            m0_tmo_q <= m0_tmo_d;
            m1_rd_q  <= m1_rd_d;
            m1_tmo_q <= m1_tmo_d;
        end
    end

    assign bus.o_Bus_CS      = (state_q == ST_ISSUE);
    assign bus.o_Bus_Wr_Rd_n = wr_q;
    assign bus.o_Bus_Addr8   = addr_q;
    assign bus.o_Bus_Wr_Data = wdata_q;

    assign bus.o_M0_Done     = (state_q == ST_DONE) && !grant_q;
    assign bus.o_M1_Done     = (state_q == ST_DONE) &&  grant_q;
    assign bus.o_M0_Rd_Data  = m0_rd_q;
    assign bus.o_M0_Timeout  = m0_tmo_q;
    assign bus.o_M1_Rd_Data  = m1_rd_q;
    assign bus.o_M1_Timeout  = m1_tmo_q;

    assign bus.o_Grant       = grant_q;
    assign bus.o_Busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus8_arbiter_x2.sv
// Self-checking bench for bus8_arbiter_x2 with a one-cycle-latency register
// bank as the slave; address 8'hF0 is dead and never returns read data.
module tb_bus8_arbiter_x2;

    localparam logic [7:0] DEAD = 8'hF0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bus8_arbiter_x2_if ifc();

    bus8_arbiter_x2 #(.TIMEOUT(16)) dut (
        .i_Bus_Clk (clk),
        .i_Bus_Rst (rst),
        .bus       (ifc)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:255];
    logic       slave_dv   = 1'b0;
    logic [7:0] slave_data = 8'h00;
    logic       stray_dv   = 1'b0;

    assign ifc.i_Bus_Rd_DV   = slave_dv | stray_dv;
    assign ifc.i_Bus_Rd_Data = stray_dv ? 8'hEE : slave_data;

    // Register bank: writes land on CS, reads answer one cycle after CS.
    always begin
        @(negedge clk);
        if (!rst && ifc.o_Bus_CS) begin
            if (ifc.o_Bus_Wr_Rd_n) begin
                mem[ifc.o_Bus_Addr8] = ifc.o_Bus_Wr_Data;
            end else if (ifc.o_Bus_Addr8 != DEAD) begin
                @(posedge clk); #1;
                slave_dv   = 1'b1;
                slave_data = mem[ifc.o_Bus_Addr8];
                @(posedge clk); #1;
                slave_dv   = 1'b0;
                slave_data = 8'h00;
            end
        end
    end

    int   cs_cnt = 0, done0_cnt = 0, done1_cnt = 0, cs_b2b = 0;
    logic cs_prev = 1'b0;

    // Event counters for CS pulses and completion pulses.
    always @(negedge clk) begin
        if (ifc.o_Bus_CS) cs_cnt++;
        if (ifc.o_Bus_CS && cs_prev) cs_b2b++;
        cs_prev = ifc.o_Bus_CS;
        if (ifc.o_M0_Done) done0_cnt++;
        if (ifc.o_M1_Done) done1_cnt++;
    end

    // Hard stop if something hangs outside the bounded waits.
    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int m, input bit v, input bit wr,
                           input logic [7:0] a, input logic [7:0] d);
        if (m == 0) begin
            ifc.i_M0_Req = v; ifc.i_M0_Wr_Rd_n = wr;
            ifc.i_M0_Addr8 = a; ifc.i_M0_Wr_Data = d;
        end else begin
            ifc.i_M1_Req = v; ifc.i_M1_Wr_Rd_n = wr;
            ifc.i_M1_Addr8 = a; ifc.i_M1_Wr_Data = d;
        end
    endtask

    // Waits for any Done pulse; cyc counts rising edges until the Done cycle.
    task automatic wait_done(input int budget, output int who, output int g,
                             output int rd, output int tmo, output int cyc);
        who = -1; g = 0; rd = 0; tmo = 0; cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (ifc.o_M0_Done || ifc.o_M1_Done) begin
                if (ifc.o_M0_Done && ifc.o_M1_Done) who = 2;
                else who = ifc.o_M1_Done ? 1 : 0;
                g   = int'(ifc.o_Grant);
                rd  = ifc.o_M1_Done ? int'(ifc.o_M1_Rd_Data) : int'(ifc.o_M0_Rd_Data);
                tmo = ifc.o_M1_Done ? int'(ifc.o_M1_Timeout) : int'(ifc.o_M0_Timeout);
                break;
            end
        end
    endtask

    // Single transaction from an idle arbiter; returns with Req dropped and idle.
    task automatic do_txn(input int m, input bit wr, input logic [7:0] a,
                          input logic [7:0] d, output int who, output int g,
                          output int rd, output int tmo, output int lat);
        set_req(m, 1'b1, wr, a, d);
        wait_done(40, who, g, rd, tmo, lat);
        @(posedge clk); #1;
        set_req(m, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int         m;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        int         exp_lat;
        bit         exp_tmo;
    } vec_t;

    vec_t vecs [8];
    int   model_rd [2];

    initial begin
        int who, g, rd, tmo, lat;
        int cs0, d0, d1;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        model_rd[0] = 0;
        model_rd[1] = 0;

        vecs[0] = '{0, 1'b1, 8'h01, 8'h7B, 8'h00, 2,  1'b0};
        vecs[1] = '{0, 1'b0, 8'h01, 8'h00, 8'h7B, 3,  1'b0};
        vecs[2] = '{1, 1'b1, 8'h02, 8'h55, 8'h00, 2,  1'b0};
        vecs[3] = '{1, 1'b0, 8'h02, 8'h00, 8'h55, 3,  1'b0};
        vecs[4] = '{1, 1'b0, DEAD,  8'h00, 8'h00, 17, 1'b1};
        vecs[5] = '{0, 1'b0, 8'h01, 8'h00, 8'h7B, 3,  1'b0};
        vecs[6] = '{0, 1'b1, 8'h03, 8'hC3, 8'h00, 2,  1'b0};
        vecs[7] = '{1, 1'b0, 8'h03, 8'h00, 8'hC3, 3,  1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  int'(ifc.o_Busy), 0);
        check("rst_cs",    int'(ifc.o_Bus_CS), 0);
        check("rst_grant", int'(ifc.o_Grant), 0);
        check("rst_done",  int'({ifc.o_M0_Done, ifc.o_M1_Done}), 0);
        check("rst_rd",    int'({ifc.o_M0_Rd_Data, ifc.o_M1_Rd_Data}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed single-master vectors
        for (int i = 0; i < 8; i++) begin
            cs0 = cs_cnt;
            d0  = done0_cnt;
            d1  = done1_cnt;
            do_txn(vecs[i].m, vecs[i].wr, vecs[i].addr, vecs[i].wdata, who, g, rd, tmo, lat);
            check($sformatf("v%0d_who", i), who, vecs[i].m);
            check($sformatf("v%0d_grant", i), g, vecs[i].m);
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_tmo", i), tmo, int'(vecs[i].exp_tmo));
            if (!vecs[i].wr) begin
                check($sformatf("v%0d_rd", i), rd, int'(vecs[i].exp_rd));
                model_rd[vecs[i].m] = int'(vecs[i].exp_rd);
            end
            check($sformatf("v%0d_cs_count", i), cs_cnt - cs0, 1);
            check($sformatf("v%0d_done_count", i), (done0_cnt - d0) + (done1_cnt - d1), 1);
            check($sformatf("v%0d_other_rd", i),
                  vecs[i].m == 0 ? int'(ifc.o_M1_Rd_Data) : int'(ifc.o_M0_Rd_Data),
                  model_rd[1 - vecs[i].m]);
        end

        // Stray DV while idle and during a write
        d0 = done0_cnt;
        d1 = done1_cnt;
        stray_dv = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("stray_idle_done", (done0_cnt - d0) + (done1_cnt - d1), 0);
        check("stray_idle_busy", int'(ifc.o_Busy), 0);
        do_txn(0, 1'b1, 8'h04, 8'h99, who, g, rd, tmo, lat);
        stray_dv = 1'b0;
        check("stray_wr_lat", lat, 2);
        check("stray_wr_done", done0_cnt - d0, 1);
        check("stray_m0_rd", int'(ifc.o_M0_Rd_Data), model_rd[0]);
        check("stray_m1_rd", int'(ifc.o_M1_Rd_Data), model_rd[1]);
        check("stray_m1_done", done1_cnt - d1, 0);

        // Simultaneous requests from reset release
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 1'b1, 1'b1, 8'h00, 8'hAA);
        set_req(1, 1'b1, 1'b1, 8'h02, 8'h55);
        @(negedge clk);
        rst = 1'b0;
        wait_done(40, who, g, rd, tmo, lat);
        check("sim_first_who", who, 0);
        check("sim_first_grant", g, 0);
        check("sim_first_lat", lat, 2);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_done(40, who, g, rd, tmo, lat);
        check("sim_second_who", who, 1);
        check("sim_second_grant", g, 1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        do_txn(0, 1'b0, 8'h00, 8'h00, who, g, rd, tmo, lat);
        check("sim_rb_addr0", rd, 8'hAA);
        do_txn(1, 1'b0, 8'h02, 8'h00, who, g, rd, tmo, lat);
        check("sim_rb_addr2", rd, 8'h55);

        // Fairness with both requests held for six transactions
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 1'b1, 1'b1, 8'h10, 8'h01);
        set_req(1, 1'b1, 1'b1, 8'h11, 8'h02);
        cs0 = cs_cnt;
        d0  = done0_cnt;
        d1  = done1_cnt;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_done(40, who, g, rd, tmo, lat);
            check($sformatf("fair%0d_grant", k), g, k % 2);
            check($sformatf("fair%0d_who", k), who, k % 2);
            if (k > 0) check($sformatf("fair%0d_gap", k), lat, 3);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("fair_m0_dones", done0_cnt - d0, 3);
        check("fair_m1_dones", done1_cnt - d1, 3);
        check("fair_cs_count", cs_cnt - cs0, 6);
        check("fair_cs_b2b", cs_b2b, 0);
        check("fair_idle_after", int'(ifc.o_Busy), 0);

        // Mid-read reset, asserted between clock edges
        do_txn(1, 1'b0, 8'h02, 8'h00, who, g, rd, tmo, lat);
        check("mr_pre_m1_rd", rd, 8'h55);
        set_req(0, 1'b1, 1'b0, DEAD, 8'h00);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mr_busy_before", int'(ifc.o_Busy), 1);
        d0 = done0_cnt;
        d1 = done1_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("mr_busy",    int'(ifc.o_Busy), 0);
        check("mr_addr",    int'(ifc.o_Bus_Addr8), 0);
        check("mr_cs",      int'(ifc.o_Bus_CS), 0);
        check("mr_done",    int'({ifc.o_M0_Done, ifc.o_M1_Done}), 0);
        check("mr_m1_rd",   int'(ifc.o_M1_Rd_Data), 0);
        check("mr_m0_rd",   int'(ifc.o_M0_Rd_Data), 0);
        check("mr_tmo",     int'({ifc.o_M0_Timeout, ifc.o_M1_Timeout}), 0);
        set_req(0, 1'b1, 1'b1, 8'h20, 8'h5A);
        set_req(1, 1'b1, 1'b1, 8'h21, 8'hA5);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mr_no_done", (done0_cnt - d0) + (done1_cnt - d1), 0);
        wait_done(40, who, g, rd, tmo, lat);
        check("mr_first_who", who, 0);
        check("mr_first_lat", lat, 2);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_done(40, who, g, rd, tmo, lat);
        check("mr_second_who", who, 1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("mr_mem20", int'(mem[8'h20]), 8'h5A);
        check("mr_mem21", int'(mem[8'h21]), 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
